// File: rtl/iter_divider.sv
// Iterative restoring divider (DIV/DIVU): one quotient bit per clock,
// start/done handshake, cancel for pipeline flush. LO = quotient, HI = remainder.
module iter_divider #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   input  logic         is_signed,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         cancel,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         r_state;
   logic           r_ready;
   logic           r_done;
   logic [N-1:0]   r_quot;
   logic [N-1:0]   r_rem_out;
   logic           r_dbz;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_dvd;      // dividend bits shift out, quotient bits shift in
   logic [N-1:0]   r_dsr;      // divisor magnitude
   logic [N-1:0]   r_rem;      // partial remainder (always < divisor magnitude)
   logic           r_q_neg;
   logic           r_r_neg;
   logic           r_dbz_pend;

   logic           w_a_neg;
   logic           w_b_neg;
   logic [N-1:0]   w_a_mag;
   logic [N-1:0]   w_b_mag;
   logic [N:0]     w_shift;
   logic [N:0]     w_diff;
   logic [N-1:0]   w_q_neg;
   logic [N-1:0]   w_r_neg;

   // Operand magnitudes; unsigned negation keeps |-2^(N-1)| exact in N bits
   always_comb begin
      w_a_neg = is_signed & dividend[N-1];
      w_b_neg = is_signed & divisor[N-1];
      w_a_mag = w_a_neg ? (~dividend + {{(N-1){1'b0}}, 1'b1}) : dividend;
      w_b_mag = w_b_neg ? (~divisor  + {{(N-1){1'b0}}, 1'b1}) : divisor;
   end

   // One restoring step: shift in next dividend bit, trial-subtract in N+1 bits
   always_comb begin
      w_shift = {r_rem, r_dvd[N-1]};
      w_diff  = w_shift - {1'b0, r_dsr};
      w_q_neg = ~r_dvd + {{(N-1){1'b0}}, 1'b1};
      w_r_neg = ~r_rem + {{(N-1){1'b0}}, 1'b1};
   end

   // Control FSM, datapath and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
         r_quot     <= '0;
         r_rem_out  <= '0;
         r_dbz      <= 1'b0;
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_dsr      <= '0;
         r_rem      <= '0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_dbz_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               // r_ready is low during the done cycle, so a start there is ignored
               if (r_ready && start && !cancel) begin
                  r_ready    <= 1'b0;
                  r_dvd      <= w_a_mag;
                  r_dsr      <= w_b_mag;
                  r_q_neg    <= w_a_neg ^ w_b_neg;
                  r_r_neg    <= w_a_neg;
                  r_dbz_pend <= (divisor == '0);
                  r_rem      <= '0;
                  r_cnt      <= CW'(N - 1);
                  r_state    <= S_CALC;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_CALC: begin
               if (cancel) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  if (!w_diff[N]) begin
                     r_rem <= w_diff[N-1:0];
                     r_dvd <= {r_dvd[N-2:0], 1'b1};
                  end else begin
                     r_rem <= w_shift[N-1:0];
                     r_dvd <= {r_dvd[N-2:0], 1'b0};
                  end
                  if (r_cnt == '0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
            end
            S_DONE: begin
               r_done    <= 1'b1;
               r_quot    <= r_dbz_pend ? '1 : (r_q_neg ? w_q_neg : r_dvd);
               r_rem_out <= r_r_neg ? w_r_neg : r_rem;
               r_dbz     <= r_dbz_pend;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready       = r_ready;
   assign done        = r_done;
   assign quotient    = r_quot;
   assign remainder   = r_rem_out;
   assign div_by_zero = r_dbz;

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle iterative restoring divider for the MIPS CPU execute stage; implements DIV/DIVU.
- Where the existing combinational adder is single-cycle addition, this unit computes by repeated shift-and-subtract, one quotient bit per clock.
- Results feed the HI (remainder) and LO (quotient) registers.
- Uses a start/done handshake so the pipeline can stall while busy and flush on exceptions.

Parameters:
- N, 32, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request a division; accepted only when ready=1.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  N  numerator; sampled with start.
- divisor  input  N  denominator; sampled with start.
- cancel  input  1  pipeline flush; aborts any operation in progress.
- ready  output  1  unit idle, can accept start.
- done  output  1  one-cycle pulse: quotient/remainder valid.
- quotient  output  N  LO result; held stable until the next accepted start.
- remainder  output  N  HI result; held stable until the next accepted start.
- div_by_zero  output  1  divisor was zero for the current result; qualified by done, held with results.

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE: ready=1. If start=1 and cancel=0 at a rising edge:
  - latch is_signed and the operand magnitudes (absolute values when is_signed=1);
  - record quotient sign = sign(dividend) XOR sign(divisor), and remainder sign = sign(dividend);
  - record divisor==0;
  - clear the partial remainder (N+1 bits); load counter=N-1; go to CALC.
- CALC: ready=0. Each cycle:
  - shift the partial remainder left by one, bringing in the next dividend MSB;
  - trial-subtract the divisor magnitude in N+1 bits;
  - if the result is non-negative, keep it and shift a 1 into the quotient, else shift a 0;
  - when the counter reaches 0, go to DONE; otherwise decrement the counter.
  - Exactly N CALC cycles.
- DONE: done=1 for exactly one cycle, and results are valid in that cycle.
  - Apply sign correction: negate the quotient if its recorded sign is 1; negate the remainder if its recorded sign is 1.
  - Return to IDLE next edge unconditionally.
- Latency: start sampled at edge k → done high in the cycle following edge k+N+1. For N=32, done is visible 33 edges after the start edge. Latency is fixed and data-independent.
- ready=0 from the edge after an accepted start through the DONE cycle. start while ready=0 is ignored, with no side effects.
- cancel:
  - in CALC, returns to IDLE at the next edge; done is never asserted for that operation; quotient/remainder keep their previous values.
  - in DONE, no effect (the done pulse already shown stands).
  - in IDLE, blocks a simultaneous start (cancel wins).
- Divide by zero (both modes): quotient = all ones, remainder = original dividend, div_by_zero=1. Latency is unchanged (full N cycles).
- Signed overflow, dividend = 100…0 and divisor = all ones with is_signed=1: quotient = 100…0, remainder = 0, div_by_zero=0. The magnitude path must use N+1-bit or unsigned arithmetic so |−2^(N−1)| is represented correctly.
- Signed results: the quotient truncates toward zero; the remainder has the sign of the dividend (or is zero); dividend = quotient·divisor + remainder always holds mod 2^N.
- Output registers update only on the DONE transition; the outputs never show intermediate values.
- resetn asserted mid-CALC: immediate return to reset values; no done pulse.

Test Plan:
- DIVU 100 / 7, N=32 → done one cycle after edge k+33; quotient=14, remainder=2, div_by_zero=0; done high exactly one cycle; ready low from edge k+1 through the done cycle.
- DIV −7 / 2 → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Also DIV 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- DIV 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0. The same operands with DIVU → quotient=0, remainder=0x80000000.
- DIVU 0x12345678 / 0 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, at normal latency.
- Start DIVU 50/5, assert start again with other operands at CALC cycle 3, then cancel at cycle 10 → second start ignored; no done; ready=1 next edge; outputs still show the prior result; a new DIVU 9/4 then yields quotient=2, remainder=1.
- Drop resetn for one cycle mid-CALC → all outputs return to 0 immediately; ready=1; no done pulse. Start with cancel=1 in IDLE → not accepted.
